// File: rtl/sram_1r1w_ctrl.sv
// Requester-side controller for a 1R1W synchronous SRAM: request stream to array strobes, 2-entry response buffer.
// Optional zero-fill sweep after reset: define SRAM_CTRL_ZERO_INIT_EN.
module sram_1r1w_ctrl #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = 320
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [DW-1:0] resp_data,
    output logic          arr_w_en,
    output logic [AW-1:0] arr_w_addr,
    output logic [DW-1:0] arr_w_data,
    output logic          arr_r_en,
    output logic [AW-1:0] arr_r_addr,
    input  logic [DW-1:0] arr_r_data,
    output logic          init_busy
);

    logic          init_active;
    logic          fire;
    logic          push;
    logic          pop;
    logic          rd_credit;
    logic [1:0]    count_q, count_d;
    logic          inflight_q, inflight_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic [DW-1:0] rbuf_q [2];
    logic [DW-1:0] rbuf_d [2];

`ifdef SRAM_CTRL_ZERO_INIT_EN
    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] init_addr_q, init_addr_d;

    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        if (state_q == ST_INIT) begin
            init_addr_d = init_addr_q + 1'b1;
            if (init_addr_q == AW'(DEPTH - 1)) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            init_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
        end
    end

    // Gated by reset_n so init_busy reads 0 while reset is held.
    assign init_active = reset_n && (state_q == ST_INIT);
    assign init_busy   = init_active;
`else
    assign init_active = 1'b0;
    assign init_busy   = 1'b0;
`endif

    assign resp_valid = (count_q != 2'd0);
    assign resp_data  = rbuf_q[rd_ptr_q];
    assign pop        = resp_valid && resp_ready;
    assign push       = inflight_q;

    // Reserve a buffer slot for every read in flight; a pop this cycle frees one.
    assign rd_credit = ({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
    assign req_ready = reset_n && !init_active && (req_write || rd_credit);
    assign fire      = req_valid && req_ready;

    always_comb begin
        arr_w_en   = fire && req_write;
        arr_w_addr = req_addr;
        arr_w_data = req_wdata;
        arr_r_en   = fire && !req_write;
        arr_r_addr = req_addr;
`ifdef SRAM_CTRL_ZERO_INIT_EN
        if (init_active) begin
            arr_w_en   = 1'b1;
            arr_w_addr = init_addr_q;
            arr_w_data = '0;
        end
`endif
    end

    always_comb begin
        rbuf_d     = rbuf_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        inflight_d = fire && !req_write;
        count_d    = count_q + {1'b0, push} - {1'b0, pop};
        if (push) begin
            rbuf_d[wr_ptr_q] = arr_r_data;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rbuf_q[0]  <= '0;
            rbuf_q[1]  <= '0;
        end else begin
            count_q    <= count_d;
            inflight_q <= inflight_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            rbuf_q     <= rbuf_d;
        end
    end

endmodule

// File: doc/sram_1r1w_ctrl.md
Name: sram_1r1w_ctrl

Overview:
- Requester-side controller for a 1R1W synchronous SRAM macro: one write port and one read port, with read data valid in the cycle after the read enable and taken from the registered address.
- Turns a single valid/ready request stream (reads and writes) into array port strobes.
- Captures read data on the only cycle it is valid and returns it through a 2-entry response buffer with backpressure.
- Sits between pipeline logic (e.g. predictor or cache tables) and the array macro.

Parameters:
- DEPTH, 64: number of array entries.
- AW, 6: address width, equal to log2(DEPTH).
- DW, 320: data width.

Ports:
- clock  in  1  single clock for the controller and the array (W0_clk = R0_clk = clock).
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid && ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  AW  entry index.
- req_wdata  in  DW  write data.
- resp_valid  out  1  read data available.
- resp_ready  in  1  consumer takes the response.
- resp_data  out  DW  read data, in request order.
- arr_w_en  out  1  to array W0_en.
- arr_w_addr  out  AW  to array W0_addr.
- arr_w_data  out  DW  to array W0_data.
- arr_r_en  out  1  to array R0_en.
- arr_r_addr  out  AW  to array R0_addr.
- arr_r_data  in  DW  from array R0_data.
- init_busy  out  1  zero-fill sweep in progress (tied 0 without the optional feature).

Behaviour:
- Array port drives are combinational from the accepted request.
  - arr_w_en = fire && req_write; arr_r_en = fire && !req_write.
  - Addresses and data pass straight through.
  - When not firing, arr_w_en = arr_r_en = 0; address and data are don't-care.
- Read pipeline:
  - A read accepted at edge N sets inflight = 1.
  - During cycle N+1, arr_r_data is captured into the response buffer at edge N+1. It is never sampled later, because a later write to the same address would corrupt it.
  - Array data is captured only when inflight = 1. On other cycles arr_r_data may be random.
- Response buffer:
  - 2-entry FIFO; count ranges 0..2.
  - resp_valid = (count != 0); resp_data = head entry.
  - Push (capture) and pop (resp_valid && resp_ready) in the same cycle: count unchanged, ordering preserved.
- Credit rule:
  - A read may be accepted only if count + inflight - pop_this_cycle < 2.
  - The buffer can therefore never overflow, and no capture is ever dropped.
- req_ready:
  - Not initializing and req_write = 1: req_ready = 1. Writes never wait for responses.
  - Not initializing and req_write = 0: req_ready = read credit available.
  - Initializing: req_ready = 0.
- Write followed by read of the same address on the next cycle returns the new data, because the array updates at the write edge.
- Write and read ordering is program order; one request per cycle.
- Reset values: req_ready = 0 while reset_n is low; count = 0, inflight = 0, resp_valid = 0, arr_w_en = 0, arr_r_en = 0, init_busy = 0.
- Reset asserted mid-operation: in-flight reads and buffered responses are discarded, with no response delivered.
- States: INIT (only with the optional feature) and RUN. Without the feature, the block enters RUN directly. In the first cycle after reset deassertion, req_ready follows the RUN rules.

Optional Feature:
- SRAM_CTRL_ZERO_INIT_EN defined:
  - After reset the FSM is in INIT with init_busy = 1.
  - A counter walks addresses 0..DEPTH-1, one per cycle, driving arr_w_en = 1, arr_w_addr = counter, arr_w_data = 0.
  - After address DEPTH-1 is written, the FSM enters RUN on the next edge and init_busy = 0.
  - INIT lasts exactly DEPTH cycles; req_ready = 0 throughout.
  - Reset asserted mid-sweep restarts the sweep from address 0.
- SRAM_CTRL_ZERO_INIT_EN undefined: no INIT state, no counter, init_busy tied 0, array contents are undefined until written.

Test Plan:
- Write addr 5 = 0xA5 (zero-extended), read addr 5 on the next cycle, resp_ready = 1 -> resp_valid 2 cycles after the write fire, resp_data = 0xA5.
- resp_ready held 0, issue reads to addr 1, 2, 3 back-to-back:
  - reads to 1 and 2 accepted; req_ready = 0 for the read to 3;
  - release resp_ready -> responses 1, 2, then 3, in order, none lost.
- Read addr 7 then write addr 7 = 0x33 on the next cycle -> the response carries the old addr-7 value, not 0x33.
- Steady stream of reads with resp_ready = 1 and count = 1 -> a push and a pop occur every cycle, count stays 1, one response per cycle.
- With SRAM_CTRL_ZERO_INIT_EN:
  - After reset, init_busy = 1 for exactly 64 cycles, 64 zero writes to addresses 0..63, req_ready = 0 throughout.
  - A read of addr 63 after the sweep returns 0.
  - Pulse reset_n low at sweep address 30 -> the sweep restarts at 0.
- Assert reset_n with an outstanding read and count = 2 -> resp_valid = 0 immediately, and no stale response is returned after release.
